// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle of the 7-segment scan driver: digit data/load/enable in,
// shared segment and anode pins plus frame pulse out.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    enable;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_tick;

  modport master (output value, dp_in, load, enable,
                  input  seg_n, dp_n, an_n, frame_tick);
  modport slave  (input  value, dp_in, load, enable,
                  output seg_n, dp_n, an_n, frame_tick);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode hex display driver with frame-aligned shadow update,
// leading-zero blanking and a per-slot anti-ghosting blank window.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_BLANK     = 1
) (
  input  logic clk,
  input  logic resetn,
  seven_seg_scan_driver_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]                cnt_q, cnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   shd_val_q, shd_val_d, dsp_val_q, dsp_val_d;
  logic [NUM_DIGITS-1:0]        shd_dp_q, shd_dp_d, dsp_dp_q, dsp_dp_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         dp_q, dp_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic                         ftick_q, ftick_d;
  logic                         slot_end, frame_end, lit, hi_zero;
  logic [NUM_DIGITS-1:0]        blank;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (cnt_q == CW'(CLK_DIV-1));
  assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS-1));

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign lit = 1'b1;
    end else begin : g_blank
      assign lit = (cnt_q >= CW'(BLANK_CYCLES));
    end
  endgenerate

  // A digit is blank when it and every more-significant digit are zero.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      hi_zero  = hi_zero && (dsp_val_q[i] == 4'h0);
      blank[i] = (LZ_BLANK != 0) && hi_zero;
    end
  end

  always_comb begin
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
    shd_val_d = shd_val_q;
    shd_dp_d  = shd_dp_q;
    if (bus.load) begin
      shd_val_d = bus.value;
      shd_dp_d  = bus.dp_in;
    end
    // Taking the next shadow value gives the load-on-boundary bypass for free.
    dsp_val_d = dsp_val_q;
    dsp_dp_d  = dsp_dp_q;
    if (frame_end) begin
      dsp_val_d = shd_val_d;
      dsp_dp_d  = shd_dp_d;
    end
    ftick_d = frame_end;
    seg_d   = blank[idx_q] ? 7'h7F : hex7(dsp_val_q[idx_q]);
    dp_d    = ~dsp_dp_q[idx_q];
    an_d    = (lit && bus.enable) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      dsp_val_q <= '0;
      dsp_dp_q  <= '0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= '1;
      ftick_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shd_val_q <= shd_val_d;
      shd_dp_q  <= shd_dp_d;
      dsp_val_q <= dsp_val_d;
      dsp_dp_q  <= dsp_dp_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      ftick_q   <= ftick_d;
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.dp_n       = dp_q;
  assign bus.an_n       = an_q;
  assign bus.frame_tick = ftick_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench: 4 digits, 4-cycle slots, 1 blank cycle; dut_a without and
// dut_b with leading-zero blanking, both fed from the same stimulus.
module tb_seven_seg_scan_driver;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.NUM_DIGITS(4)) ifa ();
  seven_seg_scan_driver_if #(.NUM_DIGITS(4)) ifb ();

  assign ifb.value  = ifa.value;
  assign ifb.dp_in  = ifa.dp_in;
  assign ifb.load   = ifa.load;
  assign ifb.enable = ifa.enable;

  seven_seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .LZ_BLANK(0))
    dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
  seven_seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .LZ_BLANK(1))
    dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ftick();
    int n;
    n = 0;
    tick();
    while (ifa.frame_tick !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_ftick", {7'b0, ifa.frame_tick}, 8'h01);
  endtask

  // Called on a frame_tick sample; walks one frame checking the lit sample of each slot.
  task automatic check_frame(input string tag, input logic [3:0][6:0] ea,
                             input logic [3:0][6:0] eb, input logic [3:0] edp);
    logic [3:0] one;
    one = 4'b0001;
    chk({tag, "_ftick"}, {7'b0, ifa.frame_tick}, 8'h01);
    for (int d = 0; d < 4; d++) begin
      tick();
      tick();
      chk($sformatf("%s_an%0d", tag, d), {4'b0, ifa.an_n}, {4'b0, ~(one << d)});
      chk($sformatf("%s_sega%0d", tag, d), {1'b0, ifa.seg_n}, {1'b0, ea[d]});
      chk($sformatf("%s_segb%0d", tag, d), {1'b0, ifb.seg_n}, {1'b0, eb[d]});
      chk($sformatf("%s_dpa%0d", tag, d), {7'b0, ifa.dp_n}, {7'b0, ~edp[d]});
      chk($sformatf("%s_dpb%0d", tag, d), {7'b0, ifb.dp_n}, {7'b0, ~edp[d]});
      tick();
      tick();
    end
  endtask

  logic [3:0] an_tab [16];

  initial begin
    an_tab = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    ifa.value  = '0;
    ifa.dp_in  = '0;
    ifa.load   = 1'b0;
    ifa.enable = 1'b1;

    // reset hold
    ticks(3);
    chk("rst_an", {4'b0, ifa.an_n}, 8'h0F);
    chk("rst_seg", {1'b0, ifa.seg_n}, 8'h7F);
    chk("rst_dp", {7'b0, ifa.dp_n}, 8'h01);
    chk("rst_ftick", {7'b0, ifa.frame_tick}, 8'h00);
    chk("rst_an_b", {4'b0, ifb.an_n}, 8'h0F);

    // release and scan pattern of the first frame
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("scan_an_k%0d", k+1), {4'b0, ifa.an_n}, {4'b0, an_tab[k]});
      if (k == 14) chk("scan_ftick15", {7'b0, ifa.frame_tick}, 8'h00);
    end
    chk("scan_ftick16", {7'b0, ifa.frame_tick}, 8'h01);
    ticks(16);
    chk("ftick_period", {7'b0, ifa.frame_tick}, 8'h01);

    // mid-frame load must not disturb the frame in progress
    ticks(5);
    ifa.value = 16'h12AF;
    ifa.load  = 1'b1;
    tick();
    ifa.load  = 1'b0;
    chk("old_disp_d1", {1'b0, ifa.seg_n}, 8'h40);
    ticks(4);
    chk("old_disp_d2", {1'b0, ifa.seg_n}, 8'h40);
    wait_ftick();
    check_frame("f12AF", {7'h79, 7'h24, 7'h08, 7'h0E}, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0000);

    // leading-zero blanking, dp on a blanked digit
    ifa.value = 16'h0050;
    ifa.dp_in = 4'b0100;
    ifa.load  = 1'b1;
    tick();
    ifa.load  = 1'b0;
    wait_ftick();
    check_frame("f0050", {7'h40, 7'h40, 7'h12, 7'h40}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0100);

    ifa.value = 16'h0000;
    ifa.dp_in = 4'b0000;
    ifa.load  = 1'b1;
    tick();
    ifa.load  = 1'b0;
    wait_ftick();
    check_frame("f0000", {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000);

    // two loads in one frame: last one wins
    ifa.value = 16'h1111;
    ifa.load  = 1'b1;
    tick();
    ifa.load  = 1'b0;
    ticks(3);
    ifa.value = 16'h2222;
    ifa.load  = 1'b1;
    tick();
    ifa.load  = 1'b0;
    wait_ftick();
    check_frame("f2222", {7'h24, 7'h24, 7'h24, 7'h24}, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000);

    // load on the boundary edge bypasses straight to the display
    ticks(15);
    chk("byp_pre_ftick", {7'b0, ifa.frame_tick}, 8'h00);
    ifa.value = 16'h3333;
    ifa.load  = 1'b1;
    tick();
    ifa.load  = 1'b0;
    check_frame("f3333", {7'h30, 7'h30, 7'h30, 7'h30}, {7'h30, 7'h30, 7'h30, 7'h30}, 4'b0000);

    // enable drop mid-slot
    ticks(2);
    chk("en_lit", {4'b0, ifa.an_n}, 8'h0E);
    ifa.enable = 1'b0;
    tick();
    chk("en_off", {4'b0, ifa.an_n}, 8'h0F);
    ticks(13);
    chk("en_off_ftick", {7'b0, ifa.frame_tick}, 8'h01);
    chk("en_off_an", {4'b0, ifa.an_n}, 8'h0F);
    ifa.enable = 1'b1;

    // asynchronous reset in slot 2
    ticks(10);
    chk("pre_rst_an", {4'b0, ifa.an_n}, 8'h0B);
    resetn = 1'b0;
    #2;
    chk("arst_an", {4'b0, ifa.an_n}, 8'h0F);
    chk("arst_seg", {1'b0, ifa.seg_n}, 8'h7F);
    chk("arst_dp", {7'b0, ifa.dp_n}, 8'h01);
    chk("arst_ftick", {7'b0, ifa.frame_tick}, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("rel_an_k1", {4'b0, ifa.an_n}, 8'h0F);
    tick();
    chk("rel_an_k2", {4'b0, ifa.an_n}, 8'h0E);
    chk("rel_sega", {1'b0, ifa.seg_n}, 8'h40);
    chk("rel_segb", {1'b0, ifb.seg_n}, 8'h40);
    ticks(14);
    chk("rel_ftick", {7'b0, ifa.frame_tick}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
